uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port rx  input  1  serial line; idle high, asynchronous to clk.
REQ-004 SHALL have port rx_enb  input  1  oversample tick, one-cycle pulse at 16x baud rate.
REQ-005 SHALL have port rd_enb  input  1  consumer acknowledge of data_out.
REQ-006 SHALL have port data_out  output  8  last received byte.
REQ-007 SHALL have port ready  output  1  data_out holds an unread byte.
REQ-008 SHALL have port busy  output  1  frame reception in progress.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: unread byte overwritten.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer, preset high; all decoding uses the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP (PARITY added per REQ-028); tick counter 4 bits, bit counter 3 bits.
REQ-013 IDLE: on rx_s==0, SHALL go to START and clear the tick counter; the tick counter advances only on rx_enb.
REQ-014 START: on the 8th rx_enb (mid-bit), SHALL go to DATA if rx_s==0, else return to IDLE (glitch reject, no flags).
REQ-015 DATA: SHALL sample rx_s every 16th rx_enb, shifting LSB-first into an internal shift register; after the 8th sample, SHALL go to STOP.
REQ-016 STOP: on the 16th rx_enb, SHALL sample rx_s and return to IDLE in the same edge, without waiting for the end of the stop bit.
REQ-017 Stop sample high: SHALL load data_out from the shift register and set ready on the next clk edge.
REQ-018 Stop sample low: SHALL pulse frame_err for exactly one cycle and leave data_out and ready unchanged.
REQ-019 ready SHALL stay high until the cycle after rd_enb is sampled high; rd_enb while ready==0 SHALL be ignored.
REQ-020 Byte completion while ready==1 and rd_enb==0: SHALL overwrite data_out, keep ready=1, and pulse overrun for one cycle.
REQ-021 Byte completion in the same cycle as rd_enb: SHALL load new data, keep ready=1, and not pulse overrun.
REQ-022 busy SHALL be high in every state other than IDLE.
REQ-023 The state machine SHALL hold state while rx_enb==0; the rd_enb/ready handshake SHALL operate every cycle regardless of rx_enb.
REQ-024 rx_s held low in IDLE after a frame_err SHALL re-enter START (break condition yields a repeated frame_err).

Reset
REQ-025 rst high at a clk edge SHALL force IDLE and clear the counters and shift register; data_out=0x00, ready=0, busy=0, frame_err=0, overrun=0; synchronizer flops=1.
REQ-026 rst mid-frame SHALL discard the partial byte; no flag pulses in or after the reset cycle.
REQ-027 rst SHALL take priority over rd_enb, rx_enb, and frame completion.

Configuration
REQ-028 With macro UART_RX_PARITY_EN defined: SHALL insert a PARITY state after DATA, sample one even-parity bit at the 16th rx_enb, and add output parity_err (1 bit, one-cycle pulse); a parity mismatch SHALL discard the byte as in REQ-018, and a stop bit sampled low SHALL still give frame_err.
REQ-029 Without UART_RX_PARITY_EN: frame = start + 8 data + stop; parity_err port and PARITY state SHALL not exist.

Verification
REQ-030 Frame 0xA5, rx_enb every 4 clk, stop high -> data_out=0xA5, ready=1 about 9.5 bit times after the falling edge; frame_err=0.
REQ-031 Low glitch of 3 rx_enb ticks on idle rx -> returns to IDLE; ready, frame_err, and busy back to 0 by tick 8.
REQ-032 Frame 0x3C with stop bit low -> one-cycle frame_err; ready stays 0; data_out unchanged.
REQ-033 Frames 0x11 then 0x22 with no rd_enb -> data_out=0x22, ready=1, one overrun pulse; repeat with rd_enb in the completion cycle -> no overrun.
REQ-034 rst asserted during data bit 4 of 0xFF, then frame 0x0F -> no flags; data_out=0x0F.
REQ-035 UART_RX_PARITY_EN defined, 0x07 with parity bit 0 -> parity_err pulse, ready=0; same byte with parity bit 1 -> ready=1, data_out=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (start + 8 data LSB-first + stop) with a ready/ack output register.
// Define UART_RX_PARITY_EN to insert an even-parity bit before the stop bit and add the parity_err output.
module uart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_enb,
  input  logic       rd_enb,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       busy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                rx_p0;
  logic                rx_s;
  logic [3:0]          tick_cnt;
  logic [2:0]          bit_cnt;
  logic [DATA_W-1:0]   shift_reg;
  logic                tick_end;
  logic                samp_data;
  logic                samp_stop;
  logic                done_ok;
  logic                done_ferr;
`ifdef UART_RX_PARITY_EN
  logic                samp_par;
  logic                par_bad;

  // Even parity: the data bits plus the parity bit must XOR to zero.
  function automatic logic par_mismatch(input logic [DATA_W-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction
`endif

  // Stage p0/s: two-flop synchronizer, preset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rx_enb) begin
      case (state)
        IDLE:   if (!rx_s) state_nxt = START;
        START:  if (tick_cnt == 4'd7) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        DATA:   if (tick_cnt == 4'd15 && bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY: if (tick_cnt == 4'd15) state_nxt = STOP;
`else
        DATA:   if (tick_cnt == 4'd15 && bit_cnt == 3'd7) state_nxt = STOP;
`endif
        STOP:   if (tick_cnt == 4'd15) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    tick_end  = rx_enb && (tick_cnt == 4'd15);
    samp_data = tick_end && (state == DATA);
    samp_stop = tick_end && (state == STOP);
    done_ferr = samp_stop && !rx_s;
`ifdef UART_RX_PARITY_EN
    samp_par  = tick_end && (state == PARITY);
    done_ok   = samp_stop && rx_s && !par_bad;
`else
    done_ok   = samp_stop && rx_s;
`endif
  end

  // START counts only to mid-bit so every later 16-tick interval lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else if (rx_enb) begin
      case (state)
        IDLE: begin
          tick_cnt <= 4'd0;
          bit_cnt  <= 3'd0;
        end
        START:   tick_cnt <= (tick_cnt == 4'd7) ? 4'd0 : tick_cnt + 4'd1;
        default: tick_cnt <= tick_cnt + 4'd1;
      endcase
      if (samp_data) begin
        shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (samp_par) par_bad <= par_mismatch(shift_reg, rx_s);
`endif
    end
  end

  // Output register: a completed byte wins over a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      ready      <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= done_ferr;
      overrun    <= done_ok && ready && !rd_enb;
`ifdef UART_RX_PARITY_EN
      parity_err <= samp_par && par_mismatch(shift_reg, rx_s);
`endif
      if (done_ok) begin
        data_out <= shift_reg;
        ready    <= 1'b1;
      end else if (rd_enb) begin
        ready    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; frames are built bit-by-bit and outcomes predicted from frame rules.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_enb;
  logic       rd_enb;
  logic [7:0] data_out;
  logic       ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  localparam bit PAR       = 1'b1;
  localparam int DONE_TICK = 168;
`else
  localparam bit PAR       = 1'b0;
  localparam int DONE_TICK = 152;
`endif

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_enb    (rx_enb),
    .rd_enb    (rd_enb),
    .data_out  (data_out),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   pe_cnt = 0;
  int   rise_cyc = 0;
  logic ready_q = 1'b0;

  // Pulse monitor: counts every cycle each flag is high, so a stretched pulse also miscounts.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
`endif
    if (ready === 1'b1 && ready_q !== 1'b1) rise_cyc <= cyc;
    ready_q <= ready;
  end

  // Reference state: last delivered byte, unread flag, expected pulse totals.
  logic [7:0] m_data = 8'h00;
  bit         m_ready = 1'b0;
  int         e_fe = 0;
  int         e_ov = 0;
  int         e_pe = 0;
  int         since = -1;
  bit         arm_rd = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One oversample tick of period per clocks; optionally acknowledges on the frame's completion tick.
  task automatic tick(input int per);
    rx_enb = 1'b1;
    if (arm_rd && since == DONE_TICK - 1) rd_enb = 1'b1;
    @(negedge clk);
    rx_enb = 1'b0;
    rd_enb = 1'b0;
    if (since >= 0) since++;
    else if (busy === 1'b1) since = 0;
    repeat (per - 1) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int per);
    rx = b;
    repeat (16) tick(per);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_data"},  data_out, m_data);
    check({tag, "_ready"}, ready, m_ready);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_ferr"},  fe_cnt, e_fe);
    check({tag, "_ovr"},   ov_cnt, e_ov);
`ifdef UART_RX_PARITY_EN
    check({tag, "_perr"},  pe_cnt, e_pe);
`endif
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input bit stop, input bit par_ok,
                            input int per, input bit rd_done);
    bit ok;
    since  = -1;
    arm_rd = rd_done;
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(d[i], per);
    if (PAR) drive_bit(par_ok ? ^d : ~(^d), per);
    drive_bit(stop, per);
    rx = 1'b1;
    repeat (4) tick(per);
    arm_rd = 1'b0;
    ok = stop && (!PAR || par_ok);
    if (PAR && !par_ok) e_pe++;
    if (!stop) e_fe++;
    if (ok) begin
      if (m_ready && !rd_done) e_ov++;
      m_data  = d;
      m_ready = 1'b1;
    end else if (rd_done) begin
      m_ready = 1'b0;
    end
    check_state(tag);
  endtask

  task automatic read_byte(input string tag);
    check({tag, "_rdata"}, data_out, m_data);
    rd_enb = 1'b1;
    @(negedge clk);
    rd_enb  = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    check({tag, "_rclr"}, ready, m_ready);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_cyc;
    int lat;
    rst = 1'b1; rx = 1'b1; rx_enb = 1'b0; rd_enb = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset");

    // Basic frame at rx_enb every 4 clocks, with ready latency around 9.5 bit times.
    start_cyc = cyc;
    send_frame("a5", 8'hA5, 1'b1, 1'b1, 4, 1'b0);
    lat = rise_cyc - start_cyc;
    check("a5_latency_in_range", (lat >= 9 * 64 && lat <= 21 * 32), 1'b1);
    read_byte("a5");

    // Short low glitch on the idle line.
    rx = 1'b0;
    repeat (3) tick(4);
    check("glitch_busy_seen", busy, 1'b1);
    rx = 1'b1;
    repeat (12) tick(4);
    check_state("glitch");

    send_frame("ferr3c", 8'h3C, 1'b0, 1'b1, 4, 1'b0);

    send_frame("f11", 8'h11, 1'b1, 1'b1, 4, 1'b0);
    send_frame("f22_ovr", 8'h22, 1'b1, 1'b1, 4, 1'b0);
    read_byte("f22");
    send_frame("g11", 8'h11, 1'b1, 1'b1, 4, 1'b0);
    send_frame("g22_ack", 8'h22, 1'b1, 1'b1, 4, 1'b1);
    read_byte("g22");

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x0F.
    since = -1;
    drive_bit(1'b0, 4);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 4);
    repeat (8) tick(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b0;
    m_data  = 8'h00;
    repeat (20) tick(4);
    check_state("midrst");
    send_frame("f0f", 8'h0F, 1'b1, 1'b1, 4, 1'b0);
    read_byte("f0f");

    // Line held low: exactly two frame errors before it is released.
    rx = 1'b0;
    repeat (2 * DONE_TICK + 4) tick(4);
    rx = 1'b1;
    repeat (24) tick(4);
    e_fe += 2;
    check_state("break");

`ifdef UART_RX_PARITY_EN
    send_frame("p07_bad", 8'h07, 1'b1, 1'b0, 4, 1'b0);
    send_frame("p07_ok",  8'h07, 1'b1, 1'b1, 4, 1'b0);
    read_byte("p07");
`endif

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit stop, par_ok, rd_done;
      int per;
      d       = 8'($urandom);
      stop    = ($urandom_range(0, 4) != 0);
      par_ok  = ($urandom_range(0, 3) != 0);
      rd_done = ($urandom_range(0, 3) == 0);
      per     = $urandom_range(2, 4);
      send_frame("rnd", d, stop, par_ok, per, rd_done);
      if ($urandom_range(0, 1) == 1) read_byte("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
